// File: rtl/zap_dbus_bridge.sv
// Data-side bridge from the ZAP core's held load/store request to a single-outstanding
// req/ack memory bus, with range/privilege aborts and a bus timeout abort.
module zap_dbus_bridge #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
  parameter logic [31:0] PROT_LIMIT = 32'h0000_0100,
  parameter int          TIMEOUT    = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_read_en,
  input  logic        i_write_en,
  input  logic [31:0] i_address,
  input  logic [3:0]  i_ben,
  input  logic [31:0] i_wr_data,
  input  logic [31:0] i_cpsr,
  output logic [31:0] o_rd_data,
  output logic        o_data_stall,
  output logic        o_data_abort,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_ben,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_abort_flag;
  logic          r_mem_req;
  logic          r_mem_we;
  logic [31:0]   r_mem_addr;
  logic [3:0]    r_mem_ben;
  logic [31:0]   r_mem_wdata;
  logic [31:0]   r_rd_data;

  logic w_req;
  logic w_user;
  logic w_bad;
  logic w_unused;

  assign w_req    = i_read_en | i_write_en;
  assign w_user   = (i_cpsr[4:0] == 5'b10000);
  assign w_bad    = (i_address >= ADDR_LIMIT) | (w_user & (i_address < PROT_LIMIT));
  assign w_unused = &{1'b0, i_cpsr[31:5]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_abort_flag <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_ben    <= '0;
      r_mem_wdata  <= '0;
      r_rd_data    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Write wins when both enables are held.
          if (w_req && !w_bad) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= i_write_en;
            r_mem_addr   <= {i_address[31:2], 2'b00};
            r_mem_ben    <= i_ben;
            r_mem_wdata  <= i_wr_data;
            r_cnt        <= '0;
            r_abort_flag <= 1'b0;
            r_state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An ack in the last allowed cycle still wins over the timeout.
          if (i_mem_ack) begin
            r_mem_req    <= 1'b0;
            r_abort_flag <= 1'b0;
            if (!r_mem_we) begin
              r_rd_data <= i_mem_rdata;
            end
            r_state <= S_DONE;
          end else if (r_cnt == LAST_WAIT) begin
            r_mem_req    <= 1'b0;
            r_abort_flag <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_data_stall = ((r_state == S_IDLE) & w_req & ~w_bad) | (r_state == S_WAIT);
  assign o_data_abort = ((r_state == S_IDLE) & w_req & w_bad) | ((r_state == S_DONE) & r_abort_flag);

  assign o_rd_data   = r_rd_data;
  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_ben   = r_mem_ben;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_zap_dbus_bridge.sv
// Self-checking bench for zap_dbus_bridge: directed vector table, hand-written
// reset/spurious-ack sequences and randomized accesses against a behavioural model.
module tb_zap_dbus_bridge;

  localparam logic [31:0] ADDR_LIMIT = 32'h0000_4000;
  localparam logic [31:0] PROT_LIMIT = 32'h0000_0100;
  localparam int          TO         = 15;

  logic        clk;
  logic        i_reset;
  logic        i_read_en;
  logic        i_write_en;
  logic [31:0] i_address;
  logic [3:0]  i_ben;
  logic [31:0] i_wr_data;
  logic [31:0] i_cpsr;
  logic [31:0] o_rd_data;
  logic        o_data_stall;
  logic        o_data_abort;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_ben;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  zap_dbus_bridge #(
    .ADDR_LIMIT(ADDR_LIMIT),
    .PROT_LIMIT(PROT_LIMIT),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_read_en   (i_read_en),
    .i_write_en  (i_write_en),
    .i_address   (i_address),
    .i_ben       (i_ben),
    .i_wr_data   (i_wr_data),
    .i_cpsr      (i_cpsr),
    .o_rd_data   (o_rd_data),
    .o_data_stall(o_data_stall),
    .o_data_abort(o_data_abort),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_ben   (o_mem_ben),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  ben;
    logic [31:0] wdata;
    logic        user;
    int          ack;
    logic [31:0] rdata;
    int          e_done;
    logic        e_abort;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drives one held request starting in the current (idle) cycle and checks what it observes.
  task automatic do_txn(input string tag, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [3:0] ben, input logic [31:0] wdata, input logic user,
                        input int ack, input logic [31:0] rdata,
                        input int e_done, input logic e_abort, input logic [31:0] e_rd);
    int          done = -1;
    int          req_cnt = 0;
    int          ab_cnt = 0;
    logic        ab_done = 1'b0;
    logic [31:0] rd_done = '0;
    logic [31:0] s_addr = '0;
    logic        s_we = 1'b0;
    logic [3:0]  s_ben = '0;
    logic [31:0] s_wdata = '0;
    logic        stable = 1'b1;
    i_read_en  = rd;
    i_write_en = wr;
    i_address  = addr;
    i_ben      = ben;
    i_wr_data  = wdata;
    i_cpsr     = user ? 32'h0000_0010 : 32'h0000_0013;
    for (int c = 0; c < 40; c++) begin
      if (c >= 1) begin
        i_address = $urandom;
        i_cpsr    = $urandom;
        i_ben     = 4'($urandom);
        i_wr_data = $urandom;
      end
      i_mem_ack   = (ack != 0) && (c == ack);
      i_mem_rdata = rdata;
      @(negedge clk);
      if (o_mem_req) req_cnt++;
      if (o_data_abort) ab_cnt++;
      if (c == 1) begin
        s_addr = o_mem_addr; s_we = o_mem_we; s_ben = o_mem_ben; s_wdata = o_mem_wdata;
      end else if (c > 1 && o_mem_req) begin
        if (o_mem_addr !== s_addr || o_mem_we !== s_we || o_mem_ben !== s_ben || o_mem_wdata !== s_wdata)
          stable = 1'b0;
      end
      if (!o_data_stall) begin
        done = c; ab_done = o_data_abort; rd_done = o_rd_data;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    i_read_en = 1'b0;
    i_write_en = 1'b0;
    i_mem_ack = 1'b0;
    $display("txn %s rd=%b wr=%b addr=%h user=%b ack=%0d done=%0d abort=%b rd_data=%h",
             tag, rd, wr, addr, user, ack, done, ab_done, rd_done);
    chk({tag, ".done_cycle"}, done, e_done);
    chk({tag, ".abort_at_done"}, {31'd0, ab_done}, {31'd0, e_abort});
    chk({tag, ".abort_pulses"}, ab_cnt, e_abort ? 1 : 0);
    chk({tag, ".rd_data"}, rd_done, e_rd);
    chk({tag, ".req_cycles"}, req_cnt, (e_done > 0) ? e_done - 1 : 0);
    if (e_done > 0) begin
      chk({tag, ".mem_addr"}, s_addr, {addr[31:2], 2'b00});
      chk({tag, ".mem_we"}, {31'd0, s_we}, {31'd0, wr});
      chk({tag, ".mem_ben"}, {28'd0, s_ben}, {28'd0, ben});
      chk({tag, ".mem_wdata"}, s_wdata, wdata);
      chk({tag, ".mem_stable"}, {31'd0, stable}, 32'd1);
    end
  endtask

  // Reference: outcome follows directly from the address rules and the ack cycle.
  task automatic model(input logic wr, input logic [31:0] addr, input logic user, input int ack,
                       input logic [31:0] rdata, inout logic [31:0] m_rd,
                       output int done, output logic abort);
    if (addr >= ADDR_LIMIT || (user && addr < PROT_LIMIT)) begin
      done = 0; abort = 1'b1;
    end else if (ack >= 1 && ack <= TO) begin
      done = ack + 1; abort = 1'b0;
      if (!wr) m_rd = rdata;
    end else begin
      done = TO + 1; abort = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] m_rd;
    logic [31:0] keep;
    i_reset = 1'b1; i_read_en = 0; i_write_en = 0; i_address = 0; i_ben = 0;
    i_wr_data = 0; i_cpsr = 32'h13; i_mem_ack = 0; i_mem_rdata = 0;

    vt[0]  = '{rd:1, wr:0, addr:32'h204,  ben:4'hF, wdata:32'h0,        user:0, ack:3,  rdata:32'hDEADBEEF, e_done:4,  e_abort:0, e_rd:32'hDEADBEEF};
    vt[1]  = '{rd:0, wr:1, addr:32'h257,  ben:4'h2, wdata:32'h0000AB00, user:0, ack:1,  rdata:32'h5A5A5A5A, e_done:2,  e_abort:0, e_rd:32'hDEADBEEF};
    vt[2]  = '{rd:1, wr:0, addr:32'h4000, ben:4'hF, wdata:32'h0,        user:0, ack:1,  rdata:32'h1,        e_done:0,  e_abort:1, e_rd:32'hDEADBEEF};
    vt[3]  = '{rd:1, wr:0, addr:32'h18,   ben:4'hF, wdata:32'h0,        user:1, ack:1,  rdata:32'h2,        e_done:0,  e_abort:1, e_rd:32'hDEADBEEF};
    vt[4]  = '{rd:1, wr:0, addr:32'h300,  ben:4'hF, wdata:32'h0,        user:0, ack:0,  rdata:32'h3,        e_done:16, e_abort:1, e_rd:32'hDEADBEEF};
    vt[5]  = '{rd:1, wr:0, addr:32'h300,  ben:4'hF, wdata:32'h0,        user:0, ack:15, rdata:32'hCAFEF00D, e_done:16, e_abort:0, e_rd:32'hCAFEF00D};
    vt[6]  = '{rd:1, wr:1, addr:32'h400,  ben:4'hF, wdata:32'h12345678, user:0, ack:2,  rdata:32'h4,        e_done:3,  e_abort:0, e_rd:32'hCAFEF00D};
    vt[7]  = '{rd:1, wr:0, addr:32'h100,  ben:4'hF, wdata:32'h0,        user:1, ack:1,  rdata:32'h11112222, e_done:2,  e_abort:0, e_rd:32'h11112222};
    vt[8]  = '{rd:1, wr:0, addr:32'h3FFC, ben:4'h3, wdata:32'h0,        user:0, ack:2,  rdata:32'h33334444, e_done:3,  e_abort:0, e_rd:32'h33334444};
    vt[9]  = '{rd:0, wr:1, addr:32'hFF,   ben:4'h1, wdata:32'h77,       user:1, ack:1,  rdata:32'h5,        e_done:0,  e_abort:1, e_rd:32'h33334444};
    vt[10] = '{rd:1, wr:0, addr:32'h10,   ben:4'hF, wdata:32'h0,        user:0, ack:1,  rdata:32'h00000055, e_done:2,  e_abort:0, e_rd:32'h00000055};

    repeat (3) @(posedge clk);
    #1 i_reset = 1'b0;
    @(negedge clk);
    chk("reset.mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("reset.mem_we", {31'd0, o_mem_we}, 32'd0);
    chk("reset.mem_addr", o_mem_addr, 32'd0);
    chk("reset.mem_wdata", o_mem_wdata, 32'd0);
    chk("reset.rd_data", o_rd_data, 32'd0);
    chk("reset.stall", {31'd0, o_data_stall}, 32'd0);
    chk("reset.abort", {31'd0, o_data_abort}, 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++)
      do_txn($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].addr, vt[i].ben, vt[i].wdata,
             vt[i].user, vt[i].ack, vt[i].rdata, vt[i].e_done, vt[i].e_abort, vt[i].e_rd);

    // Timeout, then a late ack in the following idle cycle must be ignored.
    do_txn("late_ack", 1, 0, 32'h600, 4'hF, 32'h0, 0, 0, 32'h0, TO + 1, 1, 32'h00000055);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h99999999;
    @(negedge clk);
    chk("late_ack.mem_req", {31'd0, o_mem_req}, 32'd0);
    chk("late_ack.stall", {31'd0, o_data_stall}, 32'd0);
    chk("late_ack.abort", {31'd0, o_data_abort}, 32'd0);
    @(posedge clk); #1 i_mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack.rd_data", o_rd_data, 32'h00000055);
    $display("txn spurious_ack rd_data=%h", o_rd_data);
    @(posedge clk); #1;

    // Reset in cycle 2 of a pending read drops the request without a clock edge.
    i_read_en = 1'b1; i_address = 32'h208; i_cpsr = 32'h13;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid.req_before", {31'd0, o_mem_req}, 32'd1);
    #2 i_reset = 1'b1;
    #1 chk("rst_mid.req_async", {31'd0, o_mem_req}, 32'd0);
    i_read_en = 1'b0;
    #1 chk("rst_mid.stall", {31'd0, o_data_stall}, 32'd0);
    chk("rst_mid.rd_data", o_rd_data, 32'd0);
    @(posedge clk); #1 i_reset = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'hBADBAD00;
    @(posedge clk); #1 i_mem_ack = 1'b0;
    @(negedge clk);
    chk("rst_mid.stale_ack", o_rd_data, 32'd0);
    $display("txn reset_mid_read rd_data=%h", o_rd_data);
    @(posedge clk); #1;
    do_txn("after_rst", 1, 0, 32'h208, 4'hF, 32'h0, 0, 2, 32'h00000077, 3, 0, 32'h00000077);

    m_rd = 32'h00000077;
    for (int k = 0; k < 40; k++) begin
      int          region, op, ack, e_done;
      logic        user, e_abort;
      logic [31:0] addr, rdata, wdata;
      region = $urandom_range(0, 3);
      case (region)
        0:       addr = 32'($urandom_range(0, 'hFF));
        1:       addr = 32'($urandom_range('h100, 'h3FFF));
        2:       addr = 32'h4000 + 32'($urandom_range(0, 'hFFFF));
        default: addr = $urandom;
      endcase
      op    = $urandom_range(1, 3);
      user  = 1'($urandom_range(0, 1));
      ack   = $urandom_range(0, 18);
      rdata = $urandom;
      wdata = $urandom;
      keep  = m_rd;
      model(op[1], addr, user, ack, rdata, m_rd, e_done, e_abort);
      do_txn($sformatf("rnd%0d", k), op[0], op[1], addr, 4'($urandom), wdata, user, ack, rdata,
             e_done, e_abort, m_rd);
      if (keep !== m_rd && op[1]) $display("txn rnd%0d model note: write changed read data", k);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zap_dbus_bridge.md
# zap_dbus_bridge

Data-side bus bridge that sits directly downstream of the ZAP core's data port, between the core and a slower external memory. It converts the core's level-held load/store request (i_read_en/i_write_en/i_address/i_ben/i_wr_data) into a single-outstanding req/ack memory transaction. It generates the core's o_data_stall, o_rd_data and o_data_abort. Aborts come from range and privilege checks and from a bus timeout.

## Interface
- ADDR_LIMIT, 32'h0000_4000: first illegal byte address; accesses at or above it abort.
- PROT_LIMIT, 32'h0000_0100: user-mode accesses below this byte address abort (vector/kernel region).
- TIMEOUT, 15: maximum number of WAIT cycles without i_mem_ack before a bus abort (≥1).
- i_clk  in  1  core clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_read_en  in  1  core load request, held until stall drops.
- i_write_en  in  1  core store request, held until stall drops.
- i_address  in  32  core byte address.
- i_ben  in  4  byte enables.
- i_wr_data  in  32  store data.
- i_cpsr  in  32  core CPSR; [4:0]==5'b10000 means user mode.
- o_rd_data  out  32  load data to core, registered.
- o_data_stall  out  1  core stall, combinational.
- o_data_abort  out  1  data abort to core.
- o_mem_req  out  1  memory request, registered.
- o_mem_we  out  1  1 = write.
- o_mem_addr  out  32  word-aligned address {i_address[31:2],2'b00}.
- o_mem_ben  out  4  byte enables.
- o_mem_wdata  out  32  write data.
- i_mem_ack  in  1  memory completion, one-cycle pulse.
- i_mem_rdata  in  32  read data, valid with i_mem_ack.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- req = i_read_en | i_write_en. If both are set, the access is a write.
- bad = (i_address >= ADDR_LIMIT) | (user mode & i_address < PROT_LIMIT).
- IDLE:
  - req & !bad: latch address, ben, wdata and we into the o_mem_* registers, set o_mem_req, go to WAIT.
  - req & bad: o_data_abort=1 and o_data_stall=0 in the same cycle. No memory access; stay in IDLE.
  - !req: stay in IDLE.
- WAIT: o_mem_req=1 and all o_mem_* fields are stable.
  - i_mem_ack: clear o_mem_req. On a read, load o_rd_data from i_mem_rdata. Go to DONE with abort_flag=0.
  - No ack in the TIMEOUT-th WAIT cycle: clear o_mem_req, set abort_flag=1, go to DONE. o_rd_data is unchanged.
  - The timeout counter is $clog2(TIMEOUT+1) bits, cleared on entry to WAIT and incremented each WAIT cycle without ack. An ack arriving in the TIMEOUT-th cycle is accepted, not aborted.
- DONE: o_data_stall=0 and o_data_abort=abort_flag. The core consumes the result at this edge. Unconditionally go to IDLE.
- o_data_stall = (IDLE & req & !bad) | WAIT.
- o_data_abort = (IDLE & req & bad) | (DONE & abort_flag).
- i_mem_ack is ignored in IDLE and DONE (spurious acks have no effect).
- o_rd_data holds its last value through writes, aborts and idle cycles.
- i_cpsr and i_address are sampled only in IDLE. Changes during WAIT are ignored.

## Timing
- Reset values: o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_ben=0, o_mem_wdata=0, o_rd_data=0, abort_flag=0, timeout counter=0. o_data_stall and o_data_abort follow from state IDLE.
- Asserting reset mid-transaction forces IDLE and drops o_mem_req immediately, without waiting for a clock edge. An ack for the cancelled request that arrives later is ignored.
- Access latency, with the request presented in cycle 0 (IDLE) and stall high:
  - o_mem_req rises in cycle 1.
  - If the ack arrives in cycle n≥1, DONE occurs in cycle n+1 with o_rd_data valid.
  - Stall is high in cycles 0..n. Minimum occupancy is 3 cycles (ack in cycle 1).
- Timeout: o_mem_req is high for cycles 1..TIMEOUT, and DONE with abort occurs in cycle TIMEOUT+1.
- Range/privilege abort has zero latency. Only one abort pulse is produced per held request cycle; the core is expected to drop or redirect the request on the abort.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE.

## Test plan
- Read 0x0000_0204, user mode clear, ack in cycle 3 with rdata 0xDEADBEEF:
  - stall is high in cycles 0–3.
  - o_mem_addr=0x204 and o_mem_we=0.
  - o_rd_data=0xDEADBEEF in cycle 4; abort stays 0.
- Write 0x0000_0257, ben 4'b0010, wdata 0x0000AB00, ack in cycle 1:
  - o_mem_addr=0x254, o_mem_ben=0010, o_mem_we=1.
  - DONE occurs in cycle 2 and o_rd_data is unchanged.
- Read 0x0000_4000: o_data_abort=1 and stall=0 in cycle 0; o_mem_req never rises. User-mode read 0x0000_0018 gives the same result.
- No ack with TIMEOUT=15:
  - o_mem_req is high in cycles 1–15.
  - Cycle 16 shows abort=1 and stall=0.
  - An ack arriving in cycle 17 is ignored.
  - Repeat with the ack in cycle 15: the access completes with no abort.
- Assert i_reset in cycle 2 of a pending read: o_mem_req drops asynchronously and the state returns to IDLE. A new read issued after reset completes normally.
- Both i_read_en and i_write_en set with wdata 0x12345678 gives o_mem_we=1. A spurious i_mem_ack while idle leaves o_rd_data unchanged.
